// File: rtl/matrix_vec_acc.sv
// Tiled, pipelined signed matrix-vector accumulate engine: y = sum over beats of A_k * x_k.
// Three-stage datapath (multiply, row reduce, accumulate) sequenced by a four-state job FSM.
module matrix_vec_acc #(
    parameter int unsigned M         = 16,
    parameter int unsigned N         = 16,
    parameter int unsigned DW        = 32,
    parameter int unsigned MAX_TILES = 16,
    parameter int unsigned SAT       = 1,
    localparam int unsigned TW       = $clog2(MAX_TILES + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [TW-1:0]       cfg_tiles,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DW*N*M-1:0]   mat_in,
    input  logic [DW*N-1:0]     vec_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DW*M-1:0]     res_out,
    output logic                ovf,
    output logic                busy
);

    localparam int unsigned PW    = 2 * DW;
    localparam int unsigned SW    = PW + $clog2(N);
    localparam int unsigned ACC_W = PW + $clog2(N) + $clog2(MAX_TILES);

    localparam logic signed [ACC_W-1:0] RES_MAX = ACC_W'($signed({1'b0, {(DW-1){1'b1}}}));
    localparam logic signed [ACC_W-1:0] RES_MIN = ACC_W'($signed({1'b1, {(DW-1){1'b0}}}));

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [TW-1:0] tiles_q;
    logic [TW-1:0] beats_q;
    logic [TW-1:0] tiles_clamp;
    logic          cfg_fire;
    logic          in_fire;
    logic          out_fire;
    logic          s1_vld;
    logic          s2_vld;

    logic signed [PW-1:0]    s1_prod   [M][N];
    logic signed [SW-1:0]    row_sum_c [M];
    logic signed [SW-1:0]    s2_sum    [M];
    logic signed [ACC_W-1:0] acc_q     [M];
    logic signed [ACC_W-1:0] acc_nxt   [M];
    logic [DW*M-1:0]         res_nxt;
    logic                    ovf_nxt;

    assign cfg_fire = cfg_valid && cfg_ready;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_comb begin
        tiles_clamp = cfg_tiles;
        if (cfg_tiles > TW'(MAX_TILES)) begin
            tiles_clamp = TW'(MAX_TILES);
        end
    end

    // Job sequencing; RUN always has beats outstanding, so in_ready tracks RUN.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cfg_fire) begin
                    state_nxt = (tiles_clamp == '0) ? OUT : RUN;
                end
            end
            RUN: begin
                if (in_fire && (beats_q + TW'(1) == tiles_q)) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // No beats enter while draining, so an empty S1 behind a full S2 is the last beat.
                if (s2_vld && !s1_vld) begin
                    state_nxt = OUT;
                end
            end
            OUT: begin
                if (out_fire) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Per-row reduction of the registered products.
    always_comb begin
        for (int unsigned r = 0; r < M; r++) begin
            row_sum_c[r] = '0;
            for (int unsigned c = 0; c < N; c++) begin
                row_sum_c[r] = row_sum_c[r] + SW'(s1_prod[r][c]);
            end
        end
    end

    // Accumulate and range-check every lane; the result register follows the accumulators.
    always_comb begin
        ovf_nxt = 1'b0;
        res_nxt = '0;
        for (int unsigned r = 0; r < M; r++) begin
            acc_nxt[r] = acc_q[r] + ACC_W'(s2_sum[r]);
            res_nxt[r*DW +: DW] = acc_nxt[r][DW-1:0];
            if (acc_nxt[r] > RES_MAX) begin
                ovf_nxt = 1'b1;
                if (SAT != 0) begin
                    res_nxt[r*DW +: DW] = RES_MAX[DW-1:0];
                end
            end else if (acc_nxt[r] < RES_MIN) begin
                ovf_nxt = 1'b1;
                if (SAT != 0) begin
                    res_nxt[r*DW +: DW] = RES_MIN[DW-1:0];
                end
            end
        end
    end

    // S1/S2 data registers; qualified by the valid pipeline, so no reset needed.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            for (int unsigned r = 0; r < M; r++) begin
                for (int unsigned c = 0; c < N; c++) begin
                    s1_prod[r][c] <= PW'($signed(mat_in[(r*N+c)*DW +: DW]))
                                   * PW'($signed(vec_in[c*DW +: DW]));
                end
            end
        end
        if (s1_vld) begin
            for (int unsigned r = 0; r < M; r++) begin
                s2_sum[r] <= row_sum_c[r];
            end
        end
    end

    // FSM state, registered handshake outputs, pipeline valids and accumulators.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cfg_ready <= 1'b1;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            tiles_q   <= '0;
            beats_q   <= '0;
            s1_vld    <= 1'b0;
            s2_vld    <= 1'b0;
            res_out   <= '0;
            ovf       <= 1'b0;
            for (int unsigned r = 0; r < M; r++) begin
                acc_q[r] <= '0;
            end
        end else begin
            state     <= state_nxt;
            cfg_ready <= (state_nxt == IDLE);
            in_ready  <= (state_nxt == RUN);
            out_valid <= (state_nxt == OUT);
            busy      <= (state_nxt != IDLE);
            s1_vld    <= in_fire;
            s2_vld    <= s1_vld;
            if (cfg_fire) begin
                tiles_q <= tiles_clamp;
                beats_q <= '0;
                res_out <= '0;
                ovf     <= 1'b0;
                for (int unsigned r = 0; r < M; r++) begin
                    acc_q[r] <= '0;
                end
            end else begin
                if (in_fire) begin
                    beats_q <= beats_q + TW'(1);
                end
                if (s2_vld) begin
                    res_out <= res_nxt;
                    ovf     <= ovf_nxt;
                    for (int unsigned r = 0; r < M; r++) begin
                        acc_q[r] <= acc_nxt[r];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_matrix_vec_acc.sv
// Scoreboard bench for matrix_vec_acc: a wide-integer model queues expected results per job,
// and an output monitor pops and compares them on each result handshake.
module tb_matrix_vec_acc;

    localparam int unsigned M    = 16;
    localparam int unsigned N    = 16;
    localparam int unsigned DW   = 32;
    localparam int unsigned MAXT = 16;
    localparam int unsigned TW   = $clog2(MAXT + 1);
    localparam int unsigned AW   = 2*DW + $clog2(N) + $clog2(MAXT);
    localparam int unsigned RW   = DW * M;
    localparam int unsigned MW   = DW * N * M;
    localparam int unsigned VW   = DW * N;

    typedef struct {
        logic [RW-1:0] res;
        logic          ovf;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [TW-1:0] cfg_tiles;
    logic          in_valid;
    logic          in_ready;
    logic [MW-1:0] mat_in;
    logic [VW-1:0] vec_in;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] res_out;
    logic          ovf;
    logic          busy;

    int n_tests = 0;
    int n_fail  = 0;
    exp_t sb_q[$];
    exp_t mon_e;
    logic signed [AW-1:0] acc_m [M];

    matrix_vec_acc #(.M(M), .N(N), .DW(DW), .MAX_TILES(MAXT), .SAT(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_tiles (cfg_tiles),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mat_in    (mat_in),
        .vec_in    (vec_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res_out   (res_out),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [MW-1:0] fill_mat(input logic [DW-1:0] v);
        logic [MW-1:0] m;
        for (int i = 0; i < M*N; i++) m[i*DW +: DW] = v;
        return m;
    endfunction

    function automatic logic [VW-1:0] fill_vec(input logic [DW-1:0] v);
        logic [VW-1:0] x;
        for (int i = 0; i < N; i++) x[i*DW +: DW] = v;
        return x;
    endfunction

    function automatic logic [MW-1:0] ident_mat();
        logic [MW-1:0] m;
        m = '0;
        for (int r = 0; r < M; r++) m[(r*N+r)*DW +: DW] = DW'(1);
        return m;
    endfunction

    function automatic logic [MW-1:0] rand_mat();
        logic [MW-1:0] m;
        for (int i = 0; i < M*N; i++) m[i*DW +: DW] = DW'($urandom_range(2000, 0)) - DW'(1000);
        return m;
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] x;
        for (int i = 0; i < N; i++) x[i*DW +: DW] = DW'($urandom_range(60000, 0)) - DW'(30000);
        return x;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < M; r++) acc_m[r] = '0;
    endtask

    task automatic model_beat(input logic [MW-1:0] mat, input logic [VW-1:0] vec);
        logic signed [DW-1:0] a;
        logic signed [DW-1:0] b;
        for (int r = 0; r < M; r++) begin
            for (int c = 0; c < N; c++) begin
                a = mat[(r*N+c)*DW +: DW];
                b = vec[c*DW +: DW];
                acc_m[r] = acc_m[r] + AW'(a) * AW'(b);
            end
        end
    endtask

    // Expected result with saturation to the signed DW range.
    task automatic model_push();
        exp_t e;
        logic signed [AW-1:0] hi;
        logic signed [AW-1:0] lo;
        hi = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
        lo = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};
        e.res = '0;
        e.ovf = 1'b0;
        for (int r = 0; r < M; r++) begin
            if (acc_m[r] > hi) begin
                e.res[r*DW +: DW] = hi[DW-1:0];
                e.ovf = 1'b1;
            end else if (acc_m[r] < lo) begin
                e.res[r*DW +: DW] = lo[DW-1:0];
                e.ovf = 1'b1;
            end else begin
                e.res[r*DW +: DW] = acc_m[r][DW-1:0];
            end
        end
        sb_q.push_back(e);
    endtask

    task automatic start_job(input int tiles);
        int n;
        n = 0;
        cfg_tiles = TW'(tiles);
        cfg_valid = 1'b1;
        while (!cfg_ready && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) check("cfg_wait_timeout", RW'(1'b0), RW'(1'b1));
        step();
        cfg_valid = 1'b0;
        model_clear();
    endtask

    task automatic send_beat(input logic [MW-1:0] mat, input logic [VW-1:0] vec, input int gap);
        int n;
        repeat (gap) step();
        mat_in   = mat;
        vec_in   = vec;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) check("beat_wait_timeout", RW'(1'b0), RW'(1'b1));
        step();
        in_valid = 1'b0;
        model_beat(mat, vec);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            step();
            n++;
        end
        if (sb_q.size() != 0) check("drain_timeout", RW'(sb_q.size()), RW'(0));
    endtask

    // Output monitor: compare each accepted result against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_out", RW'(1'b1), RW'(1'b0));
            end else begin
                mon_e = sb_q.pop_front();
                check("res_out", res_out, mon_e.res);
                check("ovf", RW'(ovf), RW'(mon_e.ovf));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int n;
        logic [MW-1:0] mat;
        logic [VW-1:0] vec;
        int gaps [3];

        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        cfg_tiles = '0;
        in_valid  = 1'b0;
        mat_in    = '0;
        vec_in    = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_cfg_ready", RW'(cfg_ready), RW'(1'b1));
        check("rst_in_ready", RW'(in_ready), RW'(1'b0));
        check("rst_out_valid", RW'(out_valid), RW'(1'b0));
        check("rst_res", res_out, RW'(0));
        check("rst_ovf", RW'(ovf), RW'(1'b0));
        check("rst_busy", RW'(busy), RW'(1'b0));
        rst_n = 1'b1;
        step();

        // Identity tile: result is the vector, three cycles after the beat is accepted.
        mat = ident_mat();
        for (int c = 0; c < N; c++) vec[c*DW +: DW] = DW'(c + 1);
        start_job(1);
        check("t1_busy", RW'(busy), RW'(1'b1));
        send_beat(mat, vec, 0);
        model_push();
        lat = 1;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        check("t1_latency", RW'(lat), RW'(3));
        wait_drain();

        // Four back-to-back beats of ones times twos: 128 per lane.
        start_job(4);
        for (int b = 0; b < 4; b++) send_beat(fill_mat(DW'(1)), fill_vec(DW'(2)), 0);
        model_push();
        check("t2_lane0", RW'(sb_q[0].res[DW-1:0]), RW'(128));
        check("t2_in_ready_drop", RW'(in_ready), RW'(1'b0));
        wait_drain();

        // Gapped beats with a stalled consumer: result held, no new job accepted.
        out_ready = 1'b0;
        gaps[0] = 0;
        gaps[1] = 2;
        gaps[2] = 5;
        start_job(3);
        for (int b = 0; b < 3; b++) begin
            send_beat(rand_mat(), rand_vec(), gaps[b]);
            check("t3_cfg_ready_busy", RW'(cfg_ready), RW'(1'b0));
        end
        model_push();
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        check("t3_out_valid", RW'(out_valid), RW'(1'b1));
        for (int i = 0; i < 5; i++) begin
            if (sb_q.size() != 0) check("t3_hold_res", res_out, sb_q[0].res);
            check("t3_hold_valid", RW'(out_valid), RW'(1'b1));
            check("t3_hold_cfg_ready", RW'(cfg_ready), RW'(1'b0));
            step();
        end
        out_ready = 1'b1;
        step();
        check("t3_cfg_ready_after", RW'(cfg_ready), RW'(1'b1));
        check("t3_out_valid_after", RW'(out_valid), RW'(1'b0));
        wait_drain();

        // Saturation at both ends of the range.
        start_job(1);
        send_beat(fill_mat(32'h7FFF_FFFF), fill_vec(32'h7FFF_FFFF), 0);
        model_push();
        check("t4_pos_exp_ovf", RW'(sb_q[0].ovf), RW'(1'b1));
        wait_drain();
        start_job(1);
        send_beat(fill_mat(32'h8000_0000), fill_vec(32'h7FFF_FFFF), 0);
        model_push();
        check("t4_neg_lane0", RW'(sb_q[0].res[DW-1:0]), RW'(32'h8000_0000));
        wait_drain();

        // Zero-tile job: immediate zero result, no beats requested.
        start_job(0);
        model_push();
        check("t5_out_valid", RW'(out_valid), RW'(1'b1));
        check("t5_in_ready", RW'(in_ready), RW'(1'b0));
        wait_drain();
        check("t5_in_ready_after", RW'(in_ready), RW'(1'b0));

        // Oversized tile count is clamped to the maximum.
        start_job(20);
        for (int b = 0; b < MAXT; b++) send_beat(rand_mat(), rand_vec(), 0);
        model_push();
        check("clamp_in_ready_drop", RW'(in_ready), RW'(1'b0));
        wait_drain();

        // Reset in the middle of a job aborts it without output.
        start_job(4);
        for (int b = 0; b < 2; b++) send_beat(rand_mat(), rand_vec(), 0);
        rst_n = 1'b0;
        #1;
        check("t6_cfg_ready", RW'(cfg_ready), RW'(1'b1));
        check("t6_in_ready", RW'(in_ready), RW'(1'b0));
        check("t6_out_valid", RW'(out_valid), RW'(1'b0));
        check("t6_busy", RW'(busy), RW'(1'b0));
        check("t6_res", res_out, RW'(0));
        check("t6_ovf", RW'(ovf), RW'(1'b0));
        step();
        rst_n = 1'b1;
        step();
        vec = rand_vec();
        start_job(1);
        send_beat(ident_mat(), vec, 0);
        model_push();
        check("t6_identity_exp", sb_q[0].res, RW'(vec));
        wait_drain();

        repeat (5) step();
        check("sb_empty", RW'(sb_q.size()), RW'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
